// File: rtl/alu_shift_pkg.sv
// Shared constants for the iterative ALU shift slices.
package alu_shift_pkg;

   localparam int WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic LOGICAL = 1'b0;
   localparam logic ARITH   = 1'b1;

endpackage

// File: rtl/shift_right_1bit.sv
// Combinational single-position right step with a selectable MSB fill bit.
module shift_right_1bit #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] r_in,
   input  logic             fill,
   output logic [WIDTH-1:0] r_out
);

   assign r_out = {fill, r_in[WIDTH-1:1]};

endmodule

// File: rtl/shift_right_seq.sv
// Iterative right shifter: one bit position per clock, logical or arithmetic fill,
// start/done handshake. Shift amounts >= WIDTH saturate to WIDTH steps.
module shift_right_seq
   import alu_shift_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   input  logic             arith,
   output logic [WIDTH-1:0] Z,
   output logic             busy,
   output logic             done
);

   localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] z_q, z_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fill_mode_q, fill_mode_d;

   logic [WIDTH-1:0] r_shr;
   logic             fill_bit;
   logic [CNT_W-1:0] cnt_load;

   // Full-width compare so high bits of Y always saturate; only the clamped count is kept.
   assign cnt_load = (Y >= WIDTH_V) ? CNT_MAX : Y[CNT_W-1:0];
   assign fill_bit = (fill_mode_q == ARITH) ? r_q[WIDTH-1] : 1'b0;

   shift_right_1bit #(.WIDTH(WIDTH)) u_step (
      .r_in  (r_q),
      .fill  (fill_bit),
      .r_out (r_shr)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         r_q         <= '0;
         z_q         <= '0;
         cnt_q       <= '0;
         fill_mode_q <= LOGICAL;
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         z_q         <= z_d;
         cnt_q       <= cnt_d;
         fill_mode_q <= fill_mode_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (cnt_load != '0) ? SHIFT : DONE;
         SHIFT:   if (cnt_q == CNT_ONE) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Z is captured on the edge entering DONE, so the result is valid during done.
   always_comb begin
      r_d         = r_q;
      z_d         = z_q;
      cnt_d       = cnt_q;
      fill_mode_d = fill_mode_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               r_d         = X;
               cnt_d       = cnt_load;
               fill_mode_d = arith;
               if (cnt_load == '0) z_d = X;
            end
         end
         SHIFT: begin
            r_d   = r_shr;
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) z_d = r_shr;
         end
         default: ;
      endcase
   end

   always_comb begin
      busy = (state_q != IDLE);
      done = (state_q == DONE);
   end

   assign Z = z_q;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed bench for shift_right_seq: results, latency, saturation, ignored start, reset abort.
module tb_shift_right_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] X = '0;
   logic [31:0] Y = '0;
   logic        arith = 1'b0;
   logic [31:0] Z;
   logic        busy;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   shift_right_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .X     (X),
      .Y     (Y),
      .arith (arith),
      .Z     (Z),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Issue one op from IDLE and check latency, result, busy and post-done state.
   task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                         input logic a, input logic [31:0] exp_z, input int exp_lat);
      int lat;
      X = x; Y = y; arith = a; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      X = ~x; Y = 32'd3; arith = ~a;
      lat = 1;
      while (!done && lat < 60) begin
         check({tag, "_busy_mid"}, 32'(busy), 32'd1);
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_z"}, Z, exp_z);
      check({tag, "_busy_done"}, 32'(busy), 32'd1);
      @(posedge clk); #1;
      check({tag, "_done_after"}, 32'(done), 32'd0);
      check({tag, "_busy_after"}, 32'(busy), 32'd0);
      check({tag, "_z_hold"}, Z, exp_z);
   endtask

   initial begin
      int ndone, first;
      logic [31:0] zcap;

      #12;
      check("rst_z", Z, 32'h0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("idle_busy", 32'(busy), 32'd0);

      run_op("y0",      32'b1010,      32'd0,         1'b0, 32'h0000000A, 1);
      run_op("y1",      32'b1010,      32'd1,         1'b0, 32'h00000005, 2);
      run_op("y2",      32'b1010,      32'd2,         1'b0, 32'h00000002, 3);
      run_op("ar4",     32'h80000000,  32'd4,         1'b1, 32'hF8000000, 5);
      run_op("lg4",     32'h80000000,  32'd4,         1'b0, 32'h08000000, 5);
      run_op("ar35",    32'h80000000,  32'd35,        1'b1, 32'hFFFFFFFF, 33);
      run_op("lg35",    32'b1010,      32'd35,        1'b0, 32'h00000000, 33);
      run_op("arffff",  32'h80000000,  32'hFFFFFFFF,  1'b1, 32'hFFFFFFFF, 33);
      run_op("lgffff",  32'b1010,      32'hFFFFFFFF,  1'b0, 32'h00000000, 33);
      run_op("ar32",    32'h40000000,  32'd32,        1'b1, 32'h00000000, 33);
      run_op("lg31",    32'h80000000,  32'd31,        1'b0, 32'h00000001, 32);

      // start pulses during SHIFT (cycle 2) and DONE (cycle 5) must be ignored
      X = 32'h000000F0; Y = 32'd4; arith = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0; first = 0; zcap = '0;
      for (int c = 1; c <= 12; c++) begin
         if (done) begin
            ndone++;
            if (first == 0) begin first = c; zcap = Z; end
         end
         start = (c == 2 || c == 5);
         if (c == 2) begin X = 32'h1; Y = 32'd0; arith = 1'b1; end
         @(posedge clk); #1;
      end
      start = 1'b0;
      check("ign_ndone", 32'(ndone), 32'd1);
      check("ign_lat", 32'(first), 32'd5);
      check("ign_z", zcap, 32'h0000000F);

      // reset mid-SHIFT aborts with no done pulse
      X = 32'hFFFF0000; Y = 32'd8; arith = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("abort_busy_pre", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check("abort_z", Z, 32'h0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      ndone = 0;
      for (int c = 0; c < 12; c++) begin
         if (done || busy) ndone++;
         @(posedge clk); #1;
      end
      check("abort_nodone", 32'(ndone), 32'd0);

      run_op("post_rst", 32'h10, 32'd4, 1'b0, 32'h00000001, 5);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
Multi-cycle iterative right shifter for the ALU datapath; complements the existing left-shift slices.
- Shifts operand X right by Y bit positions, one position per clock.
- Logical mode fills with zeros; arithmetic mode fills with the sign bit.
- Start/done handshake, so the ALU controller can issue right-shift ops without a combinational barrel.

Parameters:
- WIDTH, 32: operand and result width in bits.
- CNT_W, 6: width of the internal shift counter; must hold the value WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request a shift; sampled only in IDLE.
- X  input  WIDTH  operand to shift; sampled on the accepted start.
- Y  input  WIDTH  shift amount, unsigned; sampled on the accepted start.
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill); sampled on the accepted start.
- Z  output  WIDTH  result; holds its value until the next done.
- busy  output  1  high from the cycle after an accepted start until done deasserts.
- done  output  1  one-cycle pulse; Z is valid in this cycle and stays valid afterwards.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, Z=0, busy=0, done=0, working register R=0, cnt=0, stored fill mode=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1: R<=X; cnt<=min(Y,WIDTH); store arith.
  - Next state is SHIFT if min(Y,WIDTH)!=0, else DONE.
  - On start=0: remain in IDLE.
- SHIFT, once per cycle:
  - R<=R>>1, MSB filled with 0 (logical) or R[WIDTH-1] (arithmetic).
  - cnt<=cnt-1.
  - If cnt==1, go to DONE.
- DONE:
  - done=1, busy=1.
  - Z is loaded from R on the edge entering DONE, so it is valid during done.
  - Next state is always IDLE.
- Latency: done is high exactly max(1, min(Y,WIDTH)+1) cycles after the edge that samples start.
- Saturation: any Y>=WIDTH, including Y values with high bits set, gives all-zeros (logical) or all-sign-bits (arithmetic). Latency for these is WIDTH+1 cycles.
- start in SHIFT or DONE is ignored; it is not queued. A new start is accepted in IDLE the cycle after done.
- X, Y and arith may change freely after acceptance; they have no effect until the next accepted start.
- Reset during SHIFT or DONE aborts immediately to the reset values. No done pulse is produced for the aborted op.
- Width rule: Y is compared at full width against WIDTH; only the saturated value is loaded into cnt.

Decomposition:
- Package alu_shift_pkg holds:
  - WIDTH default.
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Fill-mode constants: LOGICAL=0, ARITH=1.
- One natural sub-module: shift_right_1bit, a combinational single-position right step.
  - Inputs: R[WIDTH-1:0], fill.
  - Output: R>>1 with fill inserted at the MSB.
  - Instantiated once in the SHIFT datapath; mirrors the existing left-shift slice.

Test Plan:
- X=32'b1010, Y=0, arith=0, pulse start → done 1 cycle later, Z=32'h0000000A; busy high only in the done cycle.
- X=32'b1010, Y=1, arith=0 → done 2 cycles after start, Z=32'h00000005. Repeat with Y=2 → done after 3 cycles, Z=32'h00000002.
- X=32'h80000000, Y=4, arith=1 → Z=32'hF8000000 after 5 cycles. The same input with arith=0 → Z=32'h08000000.
- X=32'h80000000, Y=35, arith=1 → Z=32'hFFFFFFFF after 33 cycles. X=32'b1010, Y=35, arith=0 → Z=0 after 33 cycles. Y=32'hFFFFFFFF → same saturated result and latency.
- Start with X=32'h000000F0, Y=4, then pulse start with X=32'h1, Y=0 while busy → ignored; a single done after 5 cycles with Z=32'h0000000F.
- Start X=32'hFFFF0000, Y=8; assert rst mid-SHIFT for 1 cycle → Z=0, busy=0, done=0 immediately, no done pulse. Then start X=32'h10, Y=4 → Z=32'h1 after 5 cycles.
